// File: rtl/cnn_stage_sequencer_pkg.sv
// rtl/cnn_stage_sequencer_pkg.sv - shared state type, limits and helpers for the stage sequencer
package cnn_stage_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_FINISH,
        ST_FAULT
    } seq_state_e;

    localparam int MAX_STAGES = 8;

    function automatic logic [MAX_STAGES-1:0] stage_onehot(input logic [2:0] idx);
        logic [MAX_STAGES-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/cnn_stage_sequencer_timeout.sv
// rtl/cnn_stage_sequencer_timeout.sv - saturating per-stage wait counter with terminal-count flag
module stage_timeout_counter #(
    parameter int          TO_W           = 24,
    parameter int unsigned TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Holding at the terminal value keeps tc asserted instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != TC_VAL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/cnn_stage_sequencer.sv
// rtl/cnn_stage_sequencer.sv - launches stage engines in order on a go edge and tracks done/timeout
module cnn_stage_sequencer
    import cnn_stage_sequencer_pkg::*;
#(
    parameter int          NUM_STAGES     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 24'd10_000_000,
    parameter int          TO_W           = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_go,
    output logic [NUM_STAGES-1:0] stage_led,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [2:0]            fault_stage
);

    seq_state_e            state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic                  go_q, go_d;
    logic [NUM_STAGES-1:0] stage_go_q, stage_go_d;
    logic [NUM_STAGES-1:0] stage_led_q, stage_led_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;
    logic [2:0]            fault_stage_q, fault_stage_d;

    logic                  start;
    logic                  stage_hit;
    logic                  cnt_clear;
    logic                  cnt_en;
    logic                  cnt_tc;
    logic [MAX_STAGES-1:0] cur_sel;
    logic [MAX_STAGES-1:0] done_ext;

    stage_timeout_counter #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    assign start     = go & ~go_q;
    assign cnt_clear = (state_d == ST_LAUNCH);
    assign cnt_en    = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);

    always_comb begin
        done_ext                 = '0;
        done_ext[NUM_STAGES-1:0] = stage_done;
        cur_sel                  = stage_onehot(idx_q);
        stage_hit                = |(cur_sel & done_ext);
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        stage_led_d   = stage_led_q;
        fault_stage_d = fault_stage_q;
        // go_q follows go even in reset so a level held through reset is not a start.
        go_d          = go;

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    state_d     = ST_LAUNCH;
                    idx_d       = '0;
                    stage_led_d = '0;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (stage_hit) begin
                    stage_led_d = stage_led_q | cur_sel[NUM_STAGES-1:0];
                    if (idx_q == 3'(NUM_STAGES - 1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_LAUNCH;
                    end
                end else if (cnt_tc) begin
                    state_d       = ST_FAULT;
                    fault_stage_d = idx_q;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        stage_go_d = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_go_d[i] = (state_d == ST_LAUNCH) && (idx_d == 3'(i));
        end
        busy_d  = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
        done_d  = (state_d == ST_FINISH);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            go_q          <= go_d;
            stage_go_q    <= '0;
            stage_led_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            go_q          <= go_d;
            stage_go_q    <= stage_go_d;
            stage_led_q   <= stage_led_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    assign stage_go    = stage_go_q;
    assign stage_led   = stage_led_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// tb/tb_cnn_stage_sequencer.sv - self-checking bench for cnn_stage_sequencer
module tb_cnn_stage_sequencer;

    localparam int N  = 5;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go = 1'b0;
    logic [N-1:0] stage_done = '0;
    logic [N-1:0] stage_go;
    logic [N-1:0] stage_led;
    logic         busy;
    logic         done;
    logic         fault;
    logic [2:0]   fault_stage;

    cnn_stage_sequencer #(
        .NUM_STAGES     (N),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .stage_done  (stage_done),
        .stage_go    (stage_go),
        .stage_led   (stage_led),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: run mode, current stage, cycles elapsed since its go pulse.
    int           m_mode = 0;
    int           m_stage = 0;
    int           m_since = 0;
    bit           m_launch = 1'b0;
    bit           m_go_prev = 1'b0;
    logic [N-1:0] e_go = '0;
    logic [N-1:0] e_led = '0;
    logic [2:0]   e_fstage = '0;

    always @(posedge clk) begin
        bit start;
        start     = go && !m_go_prev;
        m_go_prev = go;
        if (rst) begin
            m_mode   = 0;
            m_stage  = 0;
            m_since  = 0;
            m_launch = 1'b0;
            e_led    = '0;
            e_fstage = '0;
        end else begin
            case (m_mode)
                0, 2: if (start) begin
                    m_mode = 1; m_stage = 0; m_launch = 1'b1; e_led = '0;
                end
                1: begin
                    if (m_launch) begin
                        m_launch = 1'b0;
                        m_since  = 1;
                    end else if (stage_done[m_stage]) begin
                        e_led[m_stage] = 1'b1;
                        if (m_stage == N - 1) m_mode = 2;
                        else begin
                            m_stage++;
                            m_launch = 1'b1;
                        end
                    end else if (m_since == TO - 1) begin
                        m_mode   = 3;
                        e_fstage = 3'(m_stage);
                    end else begin
                        m_since++;
                    end
                end
                default: ;
            endcase
        end
        e_go = (m_mode == 1 && m_launch) ? N'(1 << m_stage) : '0;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stage_go", 32'(stage_go), 32'(e_go));
            chk("stage_led", 32'(stage_led), 32'(e_led));
            chk("busy", 32'(busy), 32'(m_mode == 1));
            chk("done", 32'(done), 32'(m_mode == 2));
            chk("fault", 32'(fault), 32'(m_mode == 3));
            chk("fault_stage", 32'(fault_stage), 32'(e_fstage));
        end
    end

    // Stage-engine stand-in: answers stage i rdly[i] cycles after its go (0 = never).
    int           rdly[N] = '{3, 3, 3, 3, 3};
    int           cd = 0;
    int           rbit = 0;
    logic [N-1:0] extra_done = '0;

    task automatic tick();
        @(negedge clk);
        stage_done = extra_done;
        extra_done = '0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) stage_done = stage_done | N'(1 << rbit);
        end
        if (stage_go != '0) begin
            for (int i = 0; i < N; i++) if (stage_go[i]) rbit = i;
            cd = rdly[rbit];
        end
    endtask

    task automatic wait_until(input int kind, input logic [N-1:0] val, input string name, output int at);
        bit hit;
        hit = 1'b0;
        at  = -1;
        for (int n = 0; n < 200 && !hit; n++) begin
            tick();
            case (kind)
                0:       hit = (stage_go == val);
                1:       hit = (done == 1'b1);
                default: hit = (fault == 1'b1);
            endcase
            if (hit) at = cyc;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_%s: not seen within 200 cycles", name);
        end
    endtask

    initial begin
        int g0, g1, g2, g3, g4, dn, f;

        // Reset held with go high: no run on release.
        rst = 1'b1;
        go  = 1'b1;
        tick();
        chk_en = 1'b1;
        repeat (4) tick();
        chk("rst_outputs", {stage_go, stage_led, busy, done, fault, fault_stage}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("held_go_no_run_busy", 32'(busy), 32'd0);
        chk("held_go_no_run_go", 32'(stage_go), 32'd0);

        // Nominal run, 3-cycle answers.
        go = 1'b0;
        tick();
        go = 1'b1;
        wait_until(0, 5'd1, "go0", g0);
        wait_until(0, 5'd2, "go1", g1);
        wait_until(0, 5'd4, "go2", g2);
        wait_until(0, 5'd8, "go3", g3);
        wait_until(0, 5'd16, "go4", g4);
        wait_until(1, '0, "done", dn);
        chk("nom_space01", 32'(g1 - g0), 32'd4);
        chk("nom_space34", 32'(g4 - g3), 32'd4);
        chk("nom_done_lat", 32'(dn - g0), 32'd20);
        chk("nom_led", 32'(stage_led), 32'd31);

        // Restart from FINISH, minimum-latency answers.
        rdly = '{1, 1, 1, 1, 1};
        go = 1'b0;
        tick();
        go = 1'b1;
        tick();
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_led", 32'(stage_led), 32'd0);
        chk("restart_go0", 32'(stage_go), 32'd1);
        g0 = cyc;
        wait_until(1, '0, "done_min", dn);
        chk("min_run", 32'(dn - g0), 32'd10);

        // Spurious done on stage 3, and stage 1 answering on its terminal-count cycle.
        rdly = '{1, 15, 1, 1, 1};
        go = 1'b0;
        tick();
        go = 1'b1;
        wait_until(0, 5'd2, "sp_go1", g1);
        tick();
        extra_done = 5'b01000;
        tick();
        tick();
        chk("spurious_led", 32'(stage_led), 32'd1);
        chk("spurious_busy", 32'(busy), 32'd1);
        wait_until(0, 5'd4, "sp_go2", g2);
        chk("tc_done_wins", 32'(g2 - g1), 32'd16);
        wait_until(1, '0, "sp_done", dn);
        chk("tc_no_fault", 32'(fault), 32'd0);

        // Stage 2 never answers.
        rdly = '{3, 3, 0, 3, 3};
        go = 1'b0;
        tick();
        go = 1'b1;
        wait_until(0, 5'd4, "to_go2", g2);
        wait_until(2, '0, "fault", f);
        chk("to_latency", 32'(f - g2), 32'd16);
        chk("to_fault_stage", 32'(fault_stage), 32'd2);
        chk("to_led", 32'(stage_led), 32'd3);
        go = 1'b0;
        tick();
        go = 1'b1;
        tick();
        tick();
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_go_ignored", 32'(stage_go), 32'd0);

        // Reset clears fault; then reset mid-run during stage 3 wait.
        rst = 1'b1;
        go  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("fault_cleared", 32'(fault), 32'd0);
        rdly = '{1, 1, 1, 0, 1};
        go = 1'b1;
        wait_until(0, 5'd8, "mr_go3", g3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        extra_done = 5'b01000;
        tick();
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_led", 32'(stage_led), 32'd0);
        chk("midrst_go", 32'(stage_go), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
